load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/load_store_unit_store_align.sv | 46 ++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store unit state type and memory funct3 codes.
package cpu_pkg;

    // Load/store unit sequencing states
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_DONE   = 2'b10
    } lsu_state_t;

    // Load width codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/load_store_unit_store_align.sv
// Combinational store lane alignment and misalignment detection.
// Byte-enables and replicated data assume a store; the caller masks them for loads.
module store_align
    import cpu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    // Decode access width into byte enables, lane-replicated data and alignment fault
    always_comb begin
        o_wstrb    = 4'b0000;
        o_wdata    = 32'h0000_0000;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB, F3_LBU: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rs2[7:0]}};
            end
            F3_LH, F3_LHU: begin
                if (i_addr_lo[1]) begin
                    o_wstrb = 4'b1100;
                end else begin
                    o_wstrb = 4'b0011;
                end
                o_wdata    = {2{i_rs2[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            F3_LW: begin
                o_wstrb    = 4'b1111;
                o_wdata    = i_rs2;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                o_wstrb    = 4'b0000;
                o_wdata    = 32'h0000_0000;
                o_misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one data-cache access per memory instruction and
// stalls the front of the pipeline until the cache accepts it.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_mem_read_i,
    input  logic            ex_mem_write_i,
    input  logic [2:0]      ex_insn_funct3_i,
    input  logic [XLEN-1:0] ex_addr_i,
    input  logic [XLEN-1:0] ex_rs2_data_i,
    input  logic            ex_flush_i,
    output logic            dc_req_o,
    output logic            dc_write_o,
    output logic [XLEN-1:0] dc_addr_o,
    output logic [3:0]      dc_wstrb_o,
    output logic [XLEN-1:0] dc_wdata_o,
    input  logic            dc_stall_i,
    input  logic [XLEN-1:0] dc_rdata_i,
    output logic            lsu_stall_o,
    output logic [XLEN-1:0] lsu_load_word_o,
    output logic            lsu_misalign_o,
    output logic [XLEN-1:0] lsu_wait_cnt_o
);

    lsu_state_t      r_state;
    lsu_state_t      w_state_next;
    logic [XLEN-1:0] r_addr;
    logic            r_write;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_load_word;
    logic            r_misalign;
    logic [XLEN-1:0] r_wait_cnt;

    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic            w_misalign;
    logic            w_op;
    logic            w_start;
    logic            w_mis_event;
    logic            w_idle;
    logic            w_access;
    logic            w_accept;

    store_align u_store_align (
        .i_funct3   (ex_insn_funct3_i),
        .i_addr_lo  (ex_addr_i[1:0]),
        .i_rs2      (ex_rs2_data_i),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    // A killed instruction neither starts an access nor raises a misalignment
    assign w_op        = ex_mem_read_i | ex_mem_write_i;
    assign w_start     = w_op & ~ex_flush_i & ~w_misalign;
    assign w_mis_event = w_op & ~ex_flush_i & w_misalign;
    assign w_idle      = (r_state == LSU_IDLE);
    assign w_access    = (r_state == LSU_ACCESS);
    assign w_accept    = w_access & ~dc_stall_i;

    // Next-state selection; DONE always falls back to IDLE so the held instruction is not reissued
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (w_start) begin
                    w_state_next = LSU_ACCESS;
                end else begin
                    w_state_next = LSU_IDLE;
                end
            end
            LSU_ACCESS: begin
                if (w_accept) begin
                    w_state_next = LSU_DONE;
                end else begin
                    w_state_next = LSU_ACCESS;
                end
            end
            LSU_DONE: w_state_next = LSU_IDLE;
            default:  w_state_next = LSU_IDLE;
        endcase
    end

    // State, latched request fields, load capture, misalign pulse and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LSU_IDLE;
            r_addr      <= 32'h0000_0000;
            r_write     <= 1'b0;
            r_wstrb     <= 4'b0000;
            r_wdata     <= 32'h0000_0000;
            r_load_word <= 32'h0000_0000;
            r_misalign  <= 1'b0;
            r_wait_cnt  <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_next;
            r_misalign <= w_idle & w_mis_event;
            if (w_idle && w_start) begin
                r_addr  <= {ex_addr_i[XLEN-1:2], 2'b00};
                r_write <= ex_mem_write_i;
                r_wstrb <= ex_mem_write_i ? w_wstrb : 4'b0000;
                r_wdata <= ex_mem_write_i ? w_wdata : 32'h0000_0000;
            end
            if (w_accept && !r_write) begin
                r_load_word <= dc_rdata_i;
            end else if (w_idle && w_mis_event) begin
                r_load_word <= 32'h0000_0000;
            end
            if (w_access && dc_stall_i && (r_wait_cnt != 32'hFFFF_FFFF)) begin
                r_wait_cnt <= r_wait_cnt + 32'h0000_0001;
            end
        end
    end

    // Cache-side fields are forced to zero whenever no request is outstanding
    assign dc_req_o        = w_access;
    assign dc_write_o      = w_access & r_write;
    assign dc_addr_o       = w_access ? r_addr  : 32'h0000_0000;
    assign dc_wstrb_o      = w_access ? r_wstrb : 4'b0000;
    assign dc_wdata_o      = w_access ? r_wdata : 32'h0000_0000;
    assign lsu_stall_o     = ~rst & ((w_idle & w_start) | w_access);
    assign lsu_load_word_o = r_load_word;
    assign lsu_misalign_o  = r_misalign;
    assign lsu_wait_cnt_o  = r_wait_cnt;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model plus directed pins.
module tb_load_store_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_read_i, ex_mem_write_i, ex_flush_i;
    logic [2:0]  ex_insn_funct3_i;
    logic [31:0] ex_addr_i, ex_rs2_data_i;
    logic        dc_req_o, dc_write_o, dc_stall_i;
    logic [31:0] dc_addr_o, dc_wdata_o, dc_rdata_i;
    logic [3:0]  dc_wstrb_o;
    logic        lsu_stall_o, lsu_misalign_o;
    logic [31:0] lsu_load_word_o, lsu_wait_cnt_o;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
        .ex_insn_funct3_i(ex_insn_funct3_i), .ex_addr_i(ex_addr_i),
        .ex_rs2_data_i(ex_rs2_data_i), .ex_flush_i(ex_flush_i),
        .dc_req_o(dc_req_o), .dc_write_o(dc_write_o), .dc_addr_o(dc_addr_o),
        .dc_wstrb_o(dc_wstrb_o), .dc_wdata_o(dc_wdata_o),
        .dc_stall_i(dc_stall_i), .dc_rdata_i(dc_rdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_load_word_o(lsu_load_word_o),
        .lsu_misalign_o(lsu_misalign_o), .lsu_wait_cnt_o(lsu_wait_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    bit          chk_en = 1'b0;
    logic        exp_req, exp_write, exp_stall, exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_addr, exp_wdata, exp_lw, exp_wait;

    // Model memory of architectural effects
    logic [31:0] m_lw = 32'h0;
    logic [31:0] m_wait = 32'h0;
    logic        m_mis = 1'b0;

    // Observation counters for the directed cases
    int          obs_req, obs_stall, obs_mis;
    logic [3:0]  obs_strb;
    logic [31:0] obs_wdata, obs_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
        logic [1:0] lo;
        lo = a[1:0];
        if (f3 == F3_LH || f3 == F3_LHU) return lo[0];
        if (f3 == F3_LW) return (lo != 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int sh;
        sh = int'(a % 32'd4);
        if (f3 == F3_SB) return 4'(1 << sh);
        if (f3 == F3_SH) return (sh >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == F3_SB) return (d % 32'd256) * 32'h0101_0101;
        if (f3 == F3_SH) return (d % 32'd65536) * 32'h0001_0001;
        return d;
    endfunction

    // Per-cycle comparison of every output against the model, plus observation counters
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dc_req", 32'(dc_req_o), 32'(exp_req));
            chk("dc_write", 32'(dc_write_o), 32'(exp_write));
            if (exp_req) chk("dc_addr", dc_addr_o, exp_addr);
            chk("dc_wstrb", 32'(dc_wstrb_o), 32'(exp_strb));
            chk("dc_wdata", dc_wdata_o, exp_wdata);
            chk("lsu_stall", 32'(lsu_stall_o), 32'(exp_stall));
            chk("misalign", 32'(lsu_misalign_o), 32'(exp_mis));
            chk("load_word", lsu_load_word_o, exp_lw);
            chk("wait_cnt", lsu_wait_cnt_o, exp_wait);
        end
        if (dc_req_o) begin
            obs_req++;
            obs_strb  = dc_wstrb_o;
            obs_wdata = dc_wdata_o;
            obs_addr  = dc_addr_o;
        end
        if (lsu_stall_o) obs_stall++;
        if (lsu_misalign_o) obs_mis++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet(input logic stall, input logic mis);
        exp_req = 1'b0; exp_write = 1'b0; exp_addr = 32'h0; exp_strb = 4'h0;
        exp_wdata = 32'h0; exp_stall = stall; exp_mis = mis;
        exp_lw = m_lw; exp_wait = m_wait;
    endtask

    task automatic clear_obs();
        obs_req = 0; obs_stall = 0; obs_mis = 0;
        obs_strb = 4'h0; obs_wdata = 32'h0; obs_addr = 32'h0;
    endtask

    // Two reset cycles; the first is unchecked, the second must show all-zero outputs
    task automatic do_reset();
        rst = 1'b1;
        chk_en = 1'b0;
        step();
        m_lw = 32'h0; m_wait = 32'h0; m_mis = 1'b0;
        chk_en = 1'b1;
        exp_quiet(1'b0, 1'b0);
        step();
        rst = 1'b0;
        ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b0; ex_flush_i = 1'b0;
        dc_stall_i = 1'b0;
    endtask

    // One instruction presented in EX; abort_k >= 0 returns before that ACCESS cycle
    task automatic run_insn(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input logic fl,
                            input int ns, input logic [31:0] rdata, input int abort_k);
        logic mis, start, mev;
        mis   = (rd | wr) & model_mis(f3, a);
        start = (rd | wr) & ~fl & ~mis;
        mev   = (rd | wr) & ~fl & mis;
        ex_mem_read_i = rd; ex_mem_write_i = wr; ex_insn_funct3_i = f3;
        ex_addr_i = a; ex_rs2_data_i = d; ex_flush_i = fl;
        dc_stall_i = 1'b0; dc_rdata_i = $urandom;
        exp_quiet(start, m_mis);
        step();
        m_mis = mev;
        if (mev) m_lw = 32'h0;
        if (start) begin
            for (int k = 0; k <= ns; k++) begin
                if (k == abort_k) return;
                dc_stall_i = (k < ns);
                dc_rdata_i = (k == ns) ? rdata : $urandom;
                exp_req = 1'b1; exp_write = wr; exp_addr = a & 32'hFFFF_FFFC;
                exp_strb = wr ? model_strb(f3, a) : 4'h0;
                exp_wdata = wr ? model_wdata(f3, d) : 32'h0;
                exp_stall = 1'b1; exp_mis = m_mis; exp_lw = m_lw; exp_wait = m_wait;
                step();
                m_mis = 1'b0;
                if (k < ns) m_wait = m_wait + 32'd1;
                else if (rd) m_lw = rdata;
            end
            // completion cycle: instruction still held, cache noise must be ignored
            dc_stall_i = 1'($urandom);
            dc_rdata_i = $urandom;
            exp_quiet(1'b0, 1'b0);
            step();
        end
    endtask

    task automatic idle_cycle();
        run_insn(1'b0, 1'b0, F3_LB, 32'h0, 32'h0, 1'b0, 0, 32'h0, -1);
    endtask

    initial begin
        logic        rd, wr, fl;
        logic [2:0]  f3;
        logic [31:0] a, w0;
        int          sel;
        logic [2:0]  ld_codes [5];
        ld_codes = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

        rst = 1'b1; ex_mem_read_i = 1'b0; ex_mem_write_i = 1'b0; ex_flush_i = 1'b0;
        ex_insn_funct3_i = 3'b000; ex_addr_i = 32'h0; ex_rs2_data_i = 32'h0;
        dc_stall_i = 1'b0; dc_rdata_i = 32'h0;
        clear_obs();
        do_reset();

        // SW 0x100, no cache stall
        clear_obs();
        run_insn(1'b0, 1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, -1);
        idle_cycle();
        chk("sw_req_cycles", 32'(obs_req), 32'd1);
        chk("sw_stall_cycles", 32'(obs_stall), 32'd2);
        chk("sw_strb", 32'(obs_strb), 32'h0000_000F);
        chk("sw_addr", obs_addr, 32'h0000_0100);
        chk("sw_wdata", obs_wdata, 32'hDEAD_BEEF);

        // SB 0x103
        clear_obs();
        run_insn(1'b0, 1'b1, F3_SB, 32'h103, 32'h0000_00A5, 1'b0, 1, 32'h0, -1);
        chk("sb_strb", 32'(obs_strb), 32'h0000_0008);
        chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", obs_addr, 32'h0000_0100);

        // SH 0x102 upper half
        clear_obs();
        run_insn(1'b0, 1'b1, F3_SH, 32'h102, 32'h1234_BEEF, 1'b0, 0, 32'h0, -1);
        chk("sh_strb", 32'(obs_strb), 32'h0000_000C);
        chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);

        // LW 0x200 with three stall cycles
        clear_obs();
        w0 = m_wait;
        run_insn(1'b1, 1'b0, F3_LW, 32'h200, 32'h0, 1'b0, 3, 32'h1234_5678, -1);
        idle_cycle();
        chk("lw_stall_cycles", 32'(obs_stall), 32'd5);
        chk("lw_load_word", lsu_load_word_o, 32'h1234_5678);
        chk("lw_wait_delta", lsu_wait_cnt_o, w0 + 32'd3);

        // SH 0x101 misaligned
        clear_obs();
        run_insn(1'b0, 1'b1, F3_SH, 32'h101, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, -1);
        idle_cycle();
        idle_cycle();
        chk("mis_req", 32'(obs_req), 32'd0);
        chk("mis_pulses", 32'(obs_mis), 32'd1);
        chk("mis_stall", 32'(obs_stall), 32'd0);
        chk("mis_load_word", lsu_load_word_o, 32'h0);

        // Flushed load in IDLE
        clear_obs();
        run_insn(1'b1, 1'b0, F3_LW, 32'h300, 32'h0, 1'b1, 0, 32'h0, -1);
        idle_cycle();
        chk("flush_req", 32'(obs_req), 32'd0);
        chk("flush_stall", 32'(obs_stall), 32'd0);

        // Reset while the cache is stalling a load
        run_insn(1'b1, 1'b0, F3_LW, 32'h400, 32'h0, 1'b0, 5, 32'h0, 2);
        chk("pre_reset_wait", lsu_wait_cnt_o, m_wait);
        dc_stall_i = 1'b1;
        do_reset();
        idle_cycle();
        chk("post_reset_wait", lsu_wait_cnt_o, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            rd = (sel >= 2) && (sel <= 5);
            wr = (sel >= 6);
            if (wr) f3 = 3'($urandom_range(0, 2));
            else    f3 = ld_codes[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            fl = ($urandom_range(0, 7) == 0);
            run_insn(rd, wr, f3, a, $urandom, fl, $urandom_range(0, 3), $urandom, -1);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
